// File: rtl/f_mult_issue_if.sv
// rtl/f_mult_issue_if.sv - operand-pair valid/ready channel into the issue buffer
interface f_mult_issue_if #(
  parameter int FLEN = 64
);
  logic            up_valid;
  logic            up_ready;
  logic [FLEN-1:0] a;
  logic [FLEN-1:0] b;

  modport master (
    output up_valid,
    output a,
    output b,
    input  up_ready
  );

  modport slave (
    input  up_valid,
    input  a,
    input  b,
    output up_ready
  );
endinterface

// File: rtl/f_mult_issue.sv
// rtl/f_mult_issue.sv - operand FIFO and issue throttle in front of the f_mult wrapper
module f_mult_issue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int FLEN         = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  f_mult_issue_if.slave                     up,
  output logic [FLEN-1:0]                   mul_a,
  output logic [FLEN-1:0]                   mul_b,
  output logic                              mul_valid,
  input  logic                              mul_busy,
  input  logic                              mul_down_valid,
  input  logic                              mul_error,
  input  logic                              err_clr,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              idle,
  output logic                              err_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [IW-1:0] MAX_L   = IW'(MAX_INFLIGHT);

  // Each entry holds {a, b}; a in the upper half.
  logic [2*FLEN-1:0] mem_q [DEPTH];

  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic            mul_valid_q, mul_valid_d;
  logic [FLEN-1:0] mul_a_q, mul_a_d;
  logic [FLEN-1:0] mul_b_q, mul_b_d;
  logic            err_q, err_d;

  logic            push;
  logic            issue;
  logic            proto_err;
  logic            err_set;
  logic [2*FLEN-1:0] head;

  // Readiness comes from the registered level only, so a full FIFO refuses
  // a pair even in a cycle where the head is being popped.
  assign up.up_ready = (level_q != DEPTH_L);

  assign head = mem_q[rptr_q];

  // Handshake, issue decision and error events for this cycle.
  always_comb begin
    push      = up.up_valid & up.up_ready;
    issue     = (level_q != '0) & !mul_busy & (inflight_q < MAX_L);
    proto_err = mul_down_valid & !issue & (inflight_q == '0);
    err_set   = (mul_down_valid & mul_error) | proto_err;
  end

  // Next-state for pointers, occupancy, in-flight count, issue register and error flag.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    inflight_d  = inflight_q;
    mul_valid_d = issue;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    err_d       = err_q;

    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end

    if (issue) begin
      rptr_d  = rptr_q + PW'(1);
      mul_a_d = head[2*FLEN-1:FLEN];
      mul_b_d = head[FLEN-1:0];
    end

    case ({push, issue})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A return with nothing outstanding saturates at zero and is flagged as a protocol error.
    case ({issue, mul_down_valid})
      2'b10: inflight_d = inflight_q + IW'(1);
      2'b01: begin
        if (inflight_q != '0) begin
          inflight_d = inflight_q - IW'(1);
        end
      end
      default: inflight_d = inflight_q;
    endcase

    // Set has priority over clear so an error in the clearing cycle is not lost.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Operand storage; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {up.a, up.b};
    end
  end

  // Control and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      inflight_q  <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      inflight_q  <= inflight_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      err_q       <= err_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_valid  = mul_valid_q;
  assign level      = level_q;
  assign inflight   = inflight_q;
  assign err_sticky = err_q;
  assign idle       = (level_q == '0) & (inflight_q == '0) & !mul_valid_q;

endmodule

// File: tb/tb_f_mult_issue.sv
// tb/tb_f_mult_issue.sv - scoreboard bench for the f_mult issue buffer
module tb_f_mult_issue;

  logic        clk;
  logic        rst;
  logic        busy_i;
  logic        dv_man;
  logic        auto_ret;
  logic        err_i;
  logic        clr_i;
  logic        dv_w;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic        mul_valid;
  logic [2:0]  level;
  logic [1:0]  inflight;
  logic        idle;
  logic        err_sticky;

  int n_cmp;
  int n_bad;
  int n_pulse;
  int p0;

  logic [127:0] exp_q [$];

  f_mult_issue_if #(.FLEN(64)) ifc ();

  f_mult_issue #(
    .DEPTH        (4),
    .MAX_INFLIGHT (2),
    .FLEN         (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .up             (ifc),
    .mul_a          (mul_a),
    .mul_b          (mul_b),
    .mul_valid      (mul_valid),
    .mul_busy       (busy_i),
    .mul_down_valid (dv_w),
    .mul_error      (err_i),
    .err_clr        (clr_i),
    .level          (level),
    .inflight       (inflight),
    .idle           (idle),
    .err_sticky     (err_sticky)
  );

  // Fake multiplier: optionally returns each product in the cycle its pulse is seen.
  assign dv_w = auto_ret ? mul_valid : dv_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_push(input logic [63:0] av, input logic [63:0] bv);
    ifc.up_valid = 1'b1;
    ifc.a        = av;
    ifc.b        = bv;
    if (ifc.up_ready) exp_q.push_back({av, bv});
    step();
    ifc.up_valid = 1'b0;
  endtask

  // Monitor: every issue pulse must carry the oldest pair accepted and not yet issued.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (!rst && mul_valid) begin
        n_pulse++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got a=%h b=%h, required no pulse", mul_a, mul_b);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_a", mul_a, e[127:64]);
          chk("pulse_b", mul_b, e[63:0]);
        end
      end
    end
  end

  logic [63:0] va [5];
  logic [63:0] vb [5];

  initial begin
    n_cmp = 0; n_bad = 0; n_pulse = 0;
    va[0] = 64'h4008000000000000; vb[0] = 64'hC010000000000000;
    va[1] = 64'h0000000000000001; vb[1] = 64'hFFFFFFFFFFFFFFFF;
    va[2] = 64'h7FF0000000000000; vb[2] = 64'h8000000000000000;
    va[3] = 64'h123456789ABCDEF0; vb[3] = 64'h0FEDCBA987654321;
    va[4] = 64'hDEADBEEFCAFEF00D; vb[4] = 64'h5555AAAA5555AAAA;

    rst = 1'b1; busy_i = 1'b0; dv_man = 1'b0; auto_ret = 1'b0;
    err_i = 1'b0; clr_i = 1'b0;
    ifc.up_valid = 1'b0; ifc.a = '0; ifc.b = '0;
    #2;
    chk("rst_level", level, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_up_ready", ifc.up_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_err", err_sticky, 0);
    step();
    rst = 1'b0;
    step();

    // Single pass-through
    do_push(64'h3FF0000000000000, 64'h4000000000000000);
    chk("t1_level_after_push", level, 1);
    chk("t1_no_pulse_yet", mul_valid, 0);
    step();
    chk("t1_pulse", mul_valid, 1);
    chk("t1_inflight", inflight, 1);
    chk("t1_level_popped", level, 0);
    step();
    chk("t1_pulse_single", mul_valid, 0);
    chk("t1_inflight_hold", inflight, 1);
    chk("t1_not_idle", idle, 0);
    dv_man = 1'b1;
    step();
    dv_man = 1'b0;
    chk("t1_inflight_ret", inflight, 0);
    chk("t1_idle", idle, 1);
    chk("t1_err", err_sticky, 0);

    // Full FIFO under busy, then drain with immediate returns
    busy_i = 1'b1; auto_ret = 1'b1;
    p0 = n_pulse;
    for (int i = 0; i < 5; i++) begin
      do_push(va[i], vb[i]);
      if (i == 3) chk("t2_full_ready", ifc.up_ready, 0);
    end
    chk("t2_level_full", level, 4);
    chk("t2_ready_low", ifc.up_ready, 0);
    chk("t2_no_issue_busy", n_pulse - p0, 0);
    busy_i = 1'b0;
    step();
    chk("t2_first_pulse", mul_valid, 1);
    chk("t2_ready_back", ifc.up_ready, 1);
    chk("t2_level_3", level, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_consecutive", mul_valid, 1);
    end
    step();
    chk("t2_pulses", n_pulse - p0, 4);
    chk("t2_done", mul_valid, 0);
    chk("t2_inflight", inflight, 0);
    chk("t2_level_0", level, 0);
    chk("t2_err", err_sticky, 0);
    auto_ret = 1'b0;

    // Inflight limit of 2 with no returns
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) do_push(va[i], vb[4-i]);
    step(); step();
    chk("t3_pulses_2", n_pulse - p0, 2);
    chk("t3_level_2", level, 2);
    chk("t3_inflight_2", inflight, 2);
    dv_man = 1'b1;
    step();
    dv_man = 1'b0;
    step(); step(); step();
    chk("t3_pulses_3", n_pulse - p0, 3);
    chk("t3_level_1", level, 1);
    chk("t3_inflight_cap", inflight, 2);

    // Issue and return in the same edge
    dv_man = 1'b1;
    step();
    chk("t4_inflight_dec", inflight, 1);
    step();
    dv_man = 1'b0;
    chk("t4_issue_and_ret", inflight, 1);
    chk("t4_pulse", mul_valid, 1);
    chk("t4_level_0", level, 0);
    dv_man = 1'b1;
    step();
    dv_man = 1'b0;
    chk("t4_drained", inflight, 0);
    chk("t4_idle", idle, 1);

    // Push and pop in the same edge at level 2
    busy_i = 1'b1;
    do_push(va[2], vb[0]);
    do_push(va[3], vb[1]);
    chk("t5_level_2", level, 2);
    busy_i = 1'b0;
    do_push(va[4], vb[2]);
    chk("t5_push_pop_level", level, 2);
    chk("t5_pulse", mul_valid, 1);
    auto_ret = 1'b1;
    for (int i = 0; i < 5; i++) step();
    auto_ret = 1'b0;
    chk("t5_level_0", level, 0);
    chk("t5_inflight_0", inflight, 0);
    chk("t5_err", err_sticky, 0);

    // Error flag
    do_push(va[1], vb[3]);
    step(); step();
    chk("t6_inflight_1", inflight, 1);
    dv_man = 1'b1; err_i = 1'b1;
    step();
    dv_man = 1'b0; err_i = 1'b0;
    chk("t6_mul_err_set", err_sticky, 1);
    chk("t6_inflight_0", inflight, 0);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t6_clr", err_sticky, 0);
    dv_man = 1'b1;
    step();
    dv_man = 1'b0;
    chk("t6_proto_err", err_sticky, 1);
    chk("t6_proto_inflight", inflight, 0);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t6_clr2", err_sticky, 0);
    clr_i = 1'b1; dv_man = 1'b1;
    step();
    clr_i = 1'b0; dv_man = 1'b0;
    chk("t6_set_wins", err_sticky, 1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("t6_clr3", err_sticky, 0);

    // Reset mid-stream: 3 queued, 1 in flight, pulse high
    busy_i = 1'b1;
    for (int i = 0; i < 4; i++) do_push(va[i], vb[i]);
    busy_i = 1'b0;
    step();
    chk("t7_level_3", level, 3);
    chk("t7_inflight_1", inflight, 1);
    chk("t7_pulse", mul_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t7_rst_level", level, 0);
    chk("t7_rst_inflight", inflight, 0);
    chk("t7_rst_mul_valid", mul_valid, 0);
    chk("t7_rst_mul_a", mul_a, 0);
    chk("t7_rst_up_ready", ifc.up_ready, 1);
    chk("t7_rst_idle", idle, 1);
    step();
    rst = 1'b0;
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) step();
    chk("t7_no_pulse_after", n_pulse - p0, 0);
    chk("t7_level_after", level, 0);
    chk("t7_err_after", err_sticky, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
